// File: rtl/bd_clkgen_if.sv
// rtl/bd_clkgen_if.sv - Reconfiguration port of bd_clkgen (divide/phase load, optional phase step).
// Step signals exist only when BD_CLKGEN_PHASE_STEP_EN is defined.
interface bd_clkgen_if #(
  parameter int CH_W  = 2,
  parameter int DIV_W = 8
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic [DIV_W-1:0] cfg_phase;
`ifdef BD_CLKGEN_PHASE_STEP_EN
  logic             step_valid;
  logic [CH_W-1:0]  step_ch;
  logic             step_dir;

  modport master (output cfg_valid, cfg_ch, cfg_div, cfg_phase, step_valid, step_ch, step_dir,
                  input  cfg_ready);
  modport slave  (input  cfg_valid, cfg_ch, cfg_div, cfg_phase, step_valid, step_ch, step_dir,
                  output cfg_ready);
`else
  modport master (output cfg_valid, cfg_ch, cfg_div, cfg_phase, input cfg_ready);
  modport slave  (input  cfg_valid, cfg_ch, cfg_div, cfg_phase, output cfg_ready);
`endif
endinterface

// File: rtl/bd_clkgen.sv
// rtl/bd_clkgen.sv - Multi-channel divided clock/strobe generator with PLL-style lock indication.
// Define BD_CLKGEN_PHASE_STEP_EN to add single-cycle phase stepping that does not relock.
module bd_clkgen #(
  parameter int                          NUM_CLOCKS = 3,
  parameter int                          DIV_W      = 8,
  parameter int                          CH_W       = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1,
  parameter logic [NUM_CLOCKS*DIV_W-1:0] DIV_INIT   = {8'd10, 8'd10, 8'd5},
  parameter logic [NUM_CLOCKS*DIV_W-1:0] PHASE_INIT = {8'd6, 8'd0, 8'd0},
  parameter int                          LOCK_DELAY = 16
) (
  input  logic                  refclk,
  input  logic                  rst,
  bd_clkgen_if.slave            cfg_bus,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic [NUM_CLOCKS-1:0] outstb,
  output logic                  locked
);
  localparam int LC_W = $clog2(LOCK_DELAY + 1);

  typedef enum logic [1:0] {ALIGN = 2'd0, LOCKING = 2'd1, LOCKED = 2'd2} state_t;

  state_t                state_q, state_d;
  logic [DIV_W-1:0]      div_q   [NUM_CLOCKS];
  logic [DIV_W-1:0]      phase_q [NUM_CLOCKS];
  logic [DIV_W-1:0]      cnt_q   [NUM_CLOCKS];
  logic [DIV_W-1:0]      div_d   [NUM_CLOCKS];
  logic [DIV_W-1:0]      phase_d [NUM_CLOCKS];
  logic [DIV_W-1:0]      cnt_d   [NUM_CLOCKS];
  logic [LC_W-1:0]       lock_cnt_q;
  logic                  cfg_ready_q;
  logic                  cfg_fire;
  logic                  cfg_hit;
  logic                  lock_done;
  logic                  locked_d;
  logic [NUM_CLOCKS-1:0] outclk_d;
  logic [NUM_CLOCKS-1:0] outstb_d;
`ifdef BD_CLKGEN_PHASE_STEP_EN
  logic                  step_fire;
`endif

  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
    return (d < DIV_W'(2)) ? DIV_W'(2) : d;
  endfunction

  function automatic logic [DIV_W-1:0] clamp_phase(input logic [DIV_W-1:0] p,
                                                   input logic [DIV_W-1:0] d);
    return (p >= d) ? d - DIV_W'(1) : p;
  endfunction

  function automatic logic [DIV_W-1:0] wrap_inc(input logic [DIV_W-1:0] c,
                                                input logic [DIV_W-1:0] d);
    return (c == d - DIV_W'(1)) ? '0 : c + DIV_W'(1);
  endfunction

  assign cfg_bus.cfg_ready = cfg_ready_q;
  // cfg_ready is high exactly in LOCKED, so it doubles as the state qualifier here
  assign cfg_fire  = cfg_bus.cfg_valid && cfg_ready_q;
  assign cfg_hit   = cfg_fire && (int'(cfg_bus.cfg_ch) < NUM_CLOCKS);
  assign lock_done = (state_q == LOCKING) && (lock_cnt_q == LC_W'(LOCK_DELAY - 1));
`ifdef BD_CLKGEN_PHASE_STEP_EN
  assign step_fire = (state_q == LOCKED) && cfg_bus.step_valid && !cfg_fire &&
                     (int'(cfg_bus.step_ch) < NUM_CLOCKS);
`endif

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q <= ALIGN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ALIGN:   state_d = LOCKING;
      LOCKING: if (lock_done) state_d = LOCKED;
      LOCKED:  if (cfg_hit) state_d = ALIGN;
      default: state_d = ALIGN;
    endcase
  end

  always_comb begin
    locked_d = (state_d == LOCKED);
    outclk_d = '0;
    outstb_d = '0;
    for (int i = 0; i < NUM_CLOCKS; i++) begin
      outclk_d[i] = locked_d && (cnt_d[i] < (div_q[i] >> 1));
      outstb_d[i] = locked_d && (cnt_d[i] == '0);
    end
  end

  // ALIGN seeds each counter so that channel i reaches zero phase_i cycles after t0
  always_comb begin
    for (int i = 0; i < NUM_CLOCKS; i++) begin
      div_d[i]   = div_q[i];
      phase_d[i] = phase_q[i];
      if (state_q == ALIGN) begin
        cnt_d[i] = (phase_q[i] == '0) ? '0 : div_q[i] - phase_q[i];
      end else begin
        cnt_d[i] = wrap_inc(cnt_q[i], div_q[i]);
      end
      if (cfg_hit && (cfg_bus.cfg_ch == CH_W'(i))) begin
        div_d[i]   = clamp_div(cfg_bus.cfg_div);
        phase_d[i] = clamp_phase(cfg_bus.cfg_phase, clamp_div(cfg_bus.cfg_div));
      end
`ifdef BD_CLKGEN_PHASE_STEP_EN
      if (step_fire && (cfg_bus.step_ch == CH_W'(i))) begin
        if (cfg_bus.step_dir) begin
          cnt_d[i]   = cnt_q[i];
          phase_d[i] = (phase_q[i] == div_q[i] - DIV_W'(1)) ? '0 : phase_q[i] + DIV_W'(1);
        end else begin
          cnt_d[i]   = wrap_inc(wrap_inc(cnt_q[i], div_q[i]), div_q[i]);
          phase_d[i] = (phase_q[i] == '0) ? div_q[i] - DIV_W'(1) : phase_q[i] - DIV_W'(1);
        end
      end
`endif
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      lock_cnt_q  <= '0;
      cfg_ready_q <= 1'b0;
      locked      <= 1'b0;
      outclk      <= '0;
      outstb      <= '0;
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        div_q[i]   <= clamp_div(DIV_INIT[i*DIV_W +: DIV_W]);
        phase_q[i] <= clamp_phase(PHASE_INIT[i*DIV_W +: DIV_W],
                                  clamp_div(DIV_INIT[i*DIV_W +: DIV_W]));
        cnt_q[i]   <= '0;
      end
    end else begin
      lock_cnt_q  <= (state_q == LOCKING) ? lock_cnt_q + LC_W'(1) : '0;
      cfg_ready_q <= locked_d;
      locked      <= locked_d;
      outclk      <= outclk_d;
      outstb      <= outstb_d;
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        div_q[i]   <= div_d[i];
        phase_q[i] <= phase_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end
endmodule

// File: tb/tb_bd_clkgen.sv
// tb/tb_bd_clkgen.sv - Self-checking bench for bd_clkgen: startup, reconfiguration, reset, phase step.
module tb_bd_clkgen;
  localparam int NC = 3;
  localparam int DW = 8;
  localparam int CW = 2;
  localparam int LD = 16;

  logic          refclk = 1'b0;
  logic          rst;
  logic [NC-1:0] outclk;
  logic [NC-1:0] outstb;
  logic          locked;

  bd_clkgen_if #(.CH_W(CW), .DIV_W(DW)) cfg_bus ();

  bd_clkgen #(
    .NUM_CLOCKS(NC), .DIV_W(DW), .CH_W(CW),
    .DIV_INIT({8'd10, 8'd10, 8'd5}), .PHASE_INIT({8'd6, 8'd0, 8'd0}), .LOCK_DELAY(LD)
  ) dut (
    .refclk(refclk), .rst(rst), .cfg_bus(cfg_bus),
    .outclk(outclk), .outstb(outstb), .locked(locked)
  );

  always #5 refclk = ~refclk;

  typedef struct packed {
    logic [CW-1:0]    ch;
    logic [DW-1:0]    div;
    logic [DW-1:0]    phase;
    logic             relock;
    logic [NC*DW-1:0] e_div;
    logic [NC*DW-1:0] e_phase;
  } cfg_vec_t;

  cfg_vec_t vecs [3];
  int exp_div   [NC];
  int exp_phase [NC];
  int k;
  int errors;
  int checks;

  task automatic chk(input string what, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s k=%0d got=%0h want=%0h", what, k, got, want);
    end
  endtask

  // Reference waveform: channel i rises phase_i cycles after t0 with period div_i
  function automatic logic [NC-1:0] model(input int n, input bit stb);
    logic [NC-1:0] r;
    int m;
    r = '0;
    for (int i = 0; i < NC; i++) begin
      m = ((n - exp_phase[i]) % exp_div[i] + exp_div[i]) % exp_div[i];
      r[i] = stb ? (m == 0) : (m < exp_div[i] / 2);
    end
    return r;
  endfunction

  task automatic set_init();
    exp_div   = '{5, 10, 10};
    exp_phase = '{0, 0, 6};
  endtask

  task automatic tick();
    @(posedge refclk);
    @(negedge refclk);
    k++;
  endtask

  task automatic check_cycle(input string tag);
    logic lk;
    lk = (k >= LD + 1);
    chk({tag, " locked"}, 32'(locked), 32'(lk));
    chk({tag, " cfg_ready"}, 32'(cfg_bus.cfg_ready), 32'(lk));
    chk({tag, " outclk"}, 32'(outclk), lk ? 32'(model(k - 1, 1'b0)) : 32'd0);
    chk({tag, " outstb"}, 32'(outstb), lk ? 32'(model(k - 1, 1'b1)) : 32'd0);
  endtask

  task automatic run_window(input string tag, input int kend);
    while (k < kend) begin
      tick();
      check_cycle(tag);
    end
  endtask

  task automatic apply_cfg(input cfg_vec_t v, input int idx);
    string tag;
    tag = $sformatf("cfg[%0d]", idx);
    chk({tag, " ready_before"}, 32'(cfg_bus.cfg_ready), 32'd1);
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_ch    = v.ch;
    cfg_bus.cfg_div   = v.div;
    cfg_bus.cfg_phase = v.phase;
    tick();
    cfg_bus.cfg_valid = 1'b0;
    for (int i = 0; i < NC; i++) begin
      exp_div[i]   = int'(v.e_div[i*DW +: DW]);
      exp_phase[i] = int'(v.e_phase[i*DW +: DW]);
    end
    if (v.relock) begin
      k = 0;
      check_cycle(tag);
      run_window(tag, 45);
    end else begin
      check_cycle(tag);
      run_window(tag, k + 20);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    k      = 0;
    rst    = 1'b1;
    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_ch    = '0;
    cfg_bus.cfg_div   = '0;
    cfg_bus.cfg_phase = '0;
`ifdef BD_CLKGEN_PHASE_STEP_EN
    cfg_bus.step_valid = 1'b0;
    cfg_bus.step_ch    = '0;
    cfg_bus.step_dir   = 1'b0;
`endif
    set_init();

    vecs[0] = '{ch: 2'd1, div: 8'd4, phase: 8'd1, relock: 1'b1,
                e_div: {8'd10, 8'd4, 8'd5}, e_phase: {8'd6, 8'd1, 8'd0}};
    vecs[1] = '{ch: 2'd0, div: 8'd1, phase: 8'd7, relock: 1'b1,
                e_div: {8'd10, 8'd4, 8'd2}, e_phase: {8'd6, 8'd1, 8'd1}};
    vecs[2] = '{ch: 2'd3, div: 8'd9, phase: 8'd2, relock: 1'b0,
                e_div: {8'd10, 8'd4, 8'd2}, e_phase: {8'd6, 8'd1, 8'd1}};

    repeat (3) @(negedge refclk);
    chk("rst locked", 32'(locked), 32'd0);
    chk("rst cfg_ready", 32'(cfg_bus.cfg_ready), 32'd0);
    chk("rst outclk", 32'(outclk), 32'd0);
    chk("rst outstb", 32'(outstb), 32'd0);

    rst = 1'b0;
    k   = 0;
    run_window("startup", 45);

    for (int v = 0; v < 3; v++) begin
      apply_cfg(vecs[v], v);
    end

    // Reset in the middle of a relock sequence must restore the power-on configuration
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_ch    = 2'd2;
    cfg_bus.cfg_div   = 8'd7;
    cfg_bus.cfg_phase = 8'd3;
    tick();
    cfg_bus.cfg_valid = 1'b0;
    k = 0;
    repeat (5) tick();
    chk("mid_locking locked", 32'(locked), 32'd0);
    rst = 1'b1;
    repeat (2) tick();
    chk("rst_pulse locked", 32'(locked), 32'd0);
    chk("rst_pulse outclk", 32'(outclk), 32'd0);
    rst = 1'b0;
    k   = 0;
    set_init();
    run_window("post_rst", 45);

`ifdef BD_CLKGEN_PHASE_STEP_EN
    cfg_bus.step_valid = 1'b1;
    cfg_bus.step_ch    = 2'd2;
    cfg_bus.step_dir   = 1'b1;
    tick();
    cfg_bus.step_valid = 1'b0;
    exp_phase[2] = 7;
    check_cycle("step_delay");
    run_window("step_delay", k + 25);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bd_clkgen.md
Name: bd_clkgen

Overview:
- Parametrised multi-channel clock/strobe generator, the successor to the fixed three-output IOPLL wrapper.
- Derives NUM_CLOCKS divided clocks and single-cycle strobes from one fabric clock.
- Each channel has its own integer divide ratio and phase offset, both reprogrammable at runtime over a valid/ready port; the block relocks after every change.
- Lock indication matches the PLL contract: downstream logic treats outputs as valid only while locked=1.

Parameters:
NUM_CLOCKS, 3, number of output channels (1..16)
DIV_W, 8, width of divide/phase values
CH_W, max(1,$clog2(NUM_CLOCKS)), channel index width
DIV_INIT, {8'd10,8'd10,8'd5}, packed per-channel reset divide ratio (ch0 in LSBs)
PHASE_INIT, {8'd6,8'd0,8'd0}, packed per-channel reset phase delay in refclk cycles
LOCK_DELAY, 16, cycles spent in LOCKING before locked asserts (>=1)

Ports:
refclk  in  1  fabric clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
cfg_valid  in  1  reconfiguration request
cfg_ready  out  1  high only in LOCKED
cfg_ch  in  CH_W  target channel
cfg_div  in  DIV_W  new divide ratio
cfg_phase  in  DIV_W  new phase delay
outclk  out  NUM_CLOCKS  divided clocks, registered
outstb  out  NUM_CLOCKS  one-cycle pulse coincident with each outclk rising cycle
locked  out  1  outputs valid

Behaviour:
- Reset values: outclk=0, outstb=0, locked=0, cfg_ready=0. div/phase registers load DIV_INIT/PHASE_INIT. state=ALIGN. Runtime configuration is lost on reset.
- Clamping on load, from either reset or cfg: div<2 becomes 2; phase>=div becomes div-1.
- Per channel: counter cnt[i] runs 0..div_i-1, increments every cycle and wraps to 0.
  - hi_i = div_i>>1.
  - outclk[i]=1 iff locked and cnt[i]<hi_i (post-edge values).
  - outstb[i]=1 iff locked and cnt[i]==0.
- ALIGN (1 cycle): sets cnt[i] = (div_i-phase_i) mod div_i. The value after this edge is alignment point t0. Channel i then rises at t0+phase_i+k*div_i. Next state is LOCKING with lock_cnt=0.
- LOCKING: counters run, outputs held 0. lock_cnt increments each cycle. On the edge where lock_cnt reaches LOCK_DELAY-1, state becomes LOCKED and locked and cfg_ready are set; outputs ungate on that same edge.
  - Net timing: locked is 1 after LOCK_DELAY+1 edges with rst sampled low.
- LOCKED: cfg_valid&cfg_ready accepts a request.
  - cfg_ch<NUM_CLOCKS: store clamped div/phase for that channel. Next edge: locked=0, cfg_ready=0, outclk/outstb=0, state=ALIGN. All channels realign, then relock after LOCK_DELAY+1 further edges.
  - cfg_ch>=NUM_CLOCKS: request is consumed and ignored; state stays LOCKED and locked stays 1.
- cfg_valid outside LOCKED is not accepted. The requester must hold it until cfg_ready.
- rst has priority over everything, including an in-flight cfg accept and an ALIGN/LOCKING sequence.

Optional Feature:
BD_CLKGEN_PHASE_STEP_EN
- With the macro defined, ports step_valid(in,1), step_ch(in,CH_W) and step_dir(in,1; 1=delay, 0=advance) are added.
- A step is accepted when state=LOCKED, step_valid=1 and step_ch valid:
  - delay: cnt[step_ch] holds one cycle, and phase is stored as (phase+1) mod div.
  - advance: cnt increments by 2 modulo div, and phase is stored as (phase-1) mod div.
- A step causes no relock and leaves locked=1. If cfg and step are accepted on the same edge, cfg wins and the step is dropped.
- Without the macro, the ports are absent and phase changes only through cfg with relock.

Test Plan:
1. Defaults, release rst -> outclk/outstb=0 for the first 16 edges, locked=1 after edge 17, cfg_ready=1.
2. After lock -> ch0 period 5 (high 2, low 3); ch1 period 10 (high 5); ch2 rises exactly 6 cycles after every ch1 rise; each outstb is 1 cycle wide on its rise.
3. LOCKED, cfg ch=1 div=4 phase=1 -> next edge locked=0 and outputs 0; relock 17 edges later; ch1 period 4 (high 2), rising 1 cycle after ch0 at t0.
4. cfg ch=0 div=1 phase=7 -> clamped to div=2 phase=1; ch0 toggles every cycle, offset 1 from t0.
5. cfg ch=3 with NUM_CLOCKS=3 -> handshake completes, locked stays 1, outputs undisturbed.
6. rst pulsed during LOCKING after test 3 -> div/phase back to INIT, locked after 17 edges, test-2 waveform reproduced. With the macro: step ch2 delay -> ch2 rise offset becomes 7, locked stays 1.
